// File: rtl/bmsce_cmp_pkg.sv
// Shared bit positions for the comparator tile's uo_out map.
package bmsce_cmp_pkg;

    localparam int unsigned GT      = 0;
    localparam int unsigned EQ      = 1;
    localparam int unsigned LT      = 2;
    localparam int unsigned CHG     = 3;
    localparam int unsigned CNT_LSB = 4;
    localparam int unsigned RES_W   = 3;

endpackage

// File: rtl/bmsce_cmp_core.sv
// Combinational unsigned magnitude compare of two WIDTH-bit operands.
module bmsce_cmp_core #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/bmsce_cmp2_top.sv
// TinyTapeout tile: registered one-hot compare flags, change strobe and
// saturating equal-event counter. rst_n is active-high despite its name.
module bmsce_cmp2_top
    import bmsce_cmp_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic             gt, eq, lt;
    logic [RES_W-1:0] res_d, res_q;
    logic [RES_W-1:0] prev_res_q;
    logic             chg_d, chg_q;
    logic [CNT_W-1:0] eq_cnt_d, eq_cnt_q;

    // Harness inputs that carry no function in this tile.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in};

    bmsce_cmp_core #(.WIDTH(WIDTH)) u_core (
        .a  (ui_in[WIDTH-1:0]),
        .b  (ui_in[2*WIDTH-1:WIDTH]),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    always_comb begin
        res_d     = '0;
        res_d[GT] = gt;
        res_d[EQ] = eq;
        res_d[LT] = lt;
    end

    // prev_res_q starts at zero so the first result after reset always strobes.
    assign chg_d = (res_d != prev_res_q);

    always_comb begin
        eq_cnt_d = eq_cnt_q;
        if (eq && (eq_cnt_q != {CNT_W{1'b1}})) begin
            eq_cnt_d = eq_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            res_q      <= '0;
            prev_res_q <= '0;
            chg_q      <= 1'b0;
            eq_cnt_q   <= '0;
        end else begin
            res_q      <= res_d;
            prev_res_q <= res_d;
            chg_q      <= chg_d;
            eq_cnt_q   <= eq_cnt_d;
        end
    end

    always_comb begin
        uo_out                      = '0;
        uo_out[RES_W-1:0]           = res_q;
        uo_out[CHG]                 = chg_q;
        uo_out[CNT_LSB +: CNT_W]    = eq_cnt_q;
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_bmsce_cmp2_top.sv
// Directed bench for bmsce_cmp2_top with a reference model feeding a scoreboard queue.
module tb_bmsce_cmp2_top;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'hFF;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];
    logic [2:0] m_prev = 3'b000;
    logic [3:0] m_cnt  = 4'h0;

    bmsce_cmp2_top #(.WIDTH(2), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic step(input logic rst, input logic [1:0] a, input logic [1:0] b,
                        input logic [3:0] junk);
        logic [2:0] r;
        logic       c;
        logic [7:0] exp;
        logic [7:0] got;
        @(negedge clk);
        rst_n  = rst;
        ui_in  = {junk, b, a};
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
        if (rst) begin
            m_prev = 3'b000;
            m_cnt  = 4'h0;
            exp    = 8'h00;
        end else begin
            r = {(a < b), (a == b), (a > b)};
            c = (r != m_prev);
            m_prev = r;
            if (r[1] && m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
            exp = {m_cnt, c, r};
        end
        sb.push_back(exp);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("uo_out", uo_out, got);
    endtask

    initial begin
        // Reset with all-ones inputs
        step(1'b1, 2'd3, 2'd3, 4'hF);
        step(1'b1, 2'd3, 2'd3, 4'hF);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);

        // Exhaustive sweep with random don't-care bits
        for (int i = 0; i < 16; i++) begin
            logic [1:0] a;
            logic [1:0] b;
            a = 2'(i);
            b = 2'(i >> 2);
            step(1'b0, a, b, 4'($urandom));
            if (a == 2'd2 && b == 2'd1) check("ex_2_1", {5'd0, uo_out[2:0]}, 8'h01);
            if (a == 2'd3 && b == 2'd3) check("ex_3_3", {5'd0, uo_out[2:0]}, 8'h02);
            if (a == 2'd0 && b == 2'd3) check("ex_0_3", {5'd0, uo_out[2:0]}, 8'h04);
        end

        // Change strobe
        step(1'b0, 2'd0, 2'd1, 4'h0);
        step(1'b0, 2'd1, 2'd1, 4'h0);
        check("chg_hold1", {7'd0, uo_out[3]}, 8'h01);
        step(1'b0, 2'd1, 2'd1, 4'h5);
        check("chg_hold2", {7'd0, uo_out[3]}, 8'h00);
        step(1'b0, 2'd1, 2'd1, 4'hA);
        check("chg_hold3", {7'd0, uo_out[3]}, 8'h00);
        step(1'b0, 2'd2, 2'd1, 4'h3);
        check("chg_gt", {4'd0, uo_out[3:0]}, 8'h09);

        // Counter saturation from a clean reset
        step(1'b1, 2'd0, 2'd0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'd0, 2'd0, 4'($urandom));
            if (i == 0)  check("cnt_first", {4'd0, uo_out[7:4]}, 8'h01);
            if (i == 14) check("cnt_reach15", {4'd0, uo_out[7:4]}, 8'h0F);
        end
        check("cnt_sat", {4'd0, uo_out[7:4]}, 8'h0F);
        step(1'b0, 2'd1, 2'd0, 4'h0);
        check("cnt_hold_neq", {4'd0, uo_out[7:4]}, 8'h0F);

        // Mid-run reset
        step(1'b1, 2'd0, 2'd0, 4'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd1, 2'd1, 4'h0);
        check("cnt_five", {4'd0, uo_out[7:4]}, 8'h05);
        step(1'b1, 2'd1, 2'd1, 4'h0);
        check("midrst_uo_out", uo_out, 8'h00);
        step(1'b0, 2'd2, 2'd2, 4'h0);
        check("post_rst", uo_out, 8'h1A);

        check("tie_uio_oe", uio_oe, 8'h00);
        check("tie_uio_out", uio_out, 8'h00);
        check("sb_empty", 8'(sb.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
